// File: rtl/alu_share_pkg.sv
// Shared ALU definitions: opcode encodings and the single-cycle evaluation function.
// Any block that needs the same 32-bit integer operation set imports this package.
package alu_share_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_SLL  = 4'd5;
    localparam logic [OP_W-1:0] OP_SRL  = 4'd6;
    localparam logic [OP_W-1:0] OP_SRA  = 4'd7;
    localparam logic [OP_W-1:0] OP_SLT  = 4'd8;
    localparam logic [OP_W-1:0] OP_SLTU = 4'd9;

    // Opcodes 10..15 are reserved and evaluate to zero.
    function automatic logic [DATA_W-1:0] alu_eval(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [OP_W-1:0]   op
    );
        logic [4:0]        shamt;
        logic [DATA_W-1:0] res;
        shamt = b[4:0];
        res   = '0;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_SLL:  res = a << shamt;
            OP_SRL:  res = a >> shamt;
            OP_SRA:  res = DATA_W'($signed(a) >>> shamt);
            OP_SLT:  res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: res = {{(DATA_W-1){1'b0}}, (a < b)};
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first valid index at or after ptr (wrapping modulo NREQ).
// Purely combinational; the caller owns the pointer register.
module rr_pick
    import alu_share_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int ID_W = 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] winner,
    output logic            any_valid
);

    logic [ID_W:0] idx;

    // Scan from the farthest offset back to ptr so the nearest valid index wins last.
    always_comb begin
        idx       = '0;
        winner    = '0;
        any_valid = |valid;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NREQ)) begin
                idx = idx - (ID_W+1)'(NREQ);
            end
            if (valid[idx[ID_W-1:0]]) begin
                winner = idx[ID_W-1:0];
            end
        end
        grant = any_valid ? (NREQ'(1) << winner) : '0;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one single-cycle 32-bit ALU among NREQ valid/ready requesters by round-robin,
// with a single registered, backpressured result channel tagged by requester ID.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [DATA_W*NREQ-1:0] req_a,
    input  logic [DATA_W*NREQ-1:0] req_b,
    input  logic [OP_W*NREQ-1:0]   req_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_result,
    output logic                   out_zero,
    output logic [ID_W-1:0]        out_id
);

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   rr_ptr_nxt;
    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   winner;
    logic              any_valid;
    logic              can_issue;
    logic              accept;
    logic [DATA_W-1:0] a_sel;
    logic [DATA_W-1:0] b_sel;
    logic [OP_W-1:0]   op_sel;
    logic [DATA_W-1:0] result;

    rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr_pick (
        .valid     (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // The output register may be refilled in the same cycle it drains.
    assign can_issue = !out_valid || out_ready;
    assign accept    = any_valid && can_issue;
    assign req_ready = rst ? '0 : (grant & {NREQ{can_issue}});

    // One-hot AND-OR operand mux keyed by the grant vector.
    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        op_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                a_sel  = a_sel  | req_a[DATA_W*i +: DATA_W];
                b_sel  = b_sel  | req_b[DATA_W*i +: DATA_W];
                op_sel = op_sel | req_op[OP_W*i +: OP_W];
            end
        end
    end

    assign result     = alu_eval(a_sel, b_sel, op_sel);
    assign rr_ptr_nxt = (winner == ID_W'(NREQ - 1)) ? '0 : winner + ID_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_id     <= '0;
            rr_ptr     <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_result <= result;
            out_zero   <= (result == '0);
            out_id     <= winner;
            rr_ptr     <= rr_ptr_nxt;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_alu_share_arbiter;

    localparam int NREQ = 3;
    localparam int ID_W = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [4*NREQ-1:0]    req_op;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_result;
    logic                 out_zero;
    logic [ID_W-1:0]      out_id;

    alu_share_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_id     (out_id)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: what the output channel should hold and whose turn is next.
    int          m_ptr  = 0;
    bit          m_ov   = 0;
    logic [31:0] m_res  = '0;
    bit          m_zero = 0;
    int          m_id   = 0;
    int          last_win;
    bit          last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        int unsigned sh;
        logic [31:0] fill;
        sh   = b % 32;
        fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return (a >> sh) | fill;
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_winner();
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] op);
        req_valid[i]      = v;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[4*i +: 4]  = op;
    endtask

    // One clock: check handshake, advance the model at the edge, check outputs after it.
    task automatic cycle();
        int w;
        logic [NREQ-1:0] exp_rdy;
        bit can;
        can     = !m_ov || out_ready;
        w       = ref_winner();
        exp_rdy = '0;
        if (!rst && w >= 0 && can) exp_rdy[w] = 1'b1;
        #1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        last_acc = (exp_rdy != '0);
        last_win = w;
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_ov = 0; m_res = '0; m_zero = 0; m_id = 0;
        end else if (last_acc) begin
            m_ov   = 1;
            m_res  = ref_alu(req_a[32*w +: 32], req_b[32*w +: 32], req_op[4*w +: 4]);
            m_zero = (m_res == 32'd0);
            m_id   = w;
            m_ptr  = (w + 1) % NREQ;
        end else if (out_ready) begin
            m_ov = 0;
        end
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_result", out_result, m_res);
        chk("out_zero", 32'(out_zero), 32'(m_zero));
        chk("out_id", 32'(out_id), 32'(m_id));
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 4))
            0:       return 32'($urandom_range(0, 40));
            1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        out_ready = 1'b1;

        // Reset then single request
        cycle();
        cycle();
        rst = 1'b0;
        set_req(0, 1, 32'd5, 32'd3, 4'd0);
        cycle();
        chk("t1_ready", 32'(req_ready), 32'h1);
        chk("t1_result", out_result, 32'd8);
        chk("t1_zero", 32'(out_zero), 32'd0);
        chk("t1_id", 32'(out_id), 32'd0);
        req_valid = '0;
        cycle();

        // Contention: reset so the pointer starts at requester 0
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        set_req(0, 1, 32'd10, 32'd10, 4'd1);
        set_req(1, 1, 32'h8000_0000, 32'd4, 4'd7);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t2_id", 32'(out_id), 32'(k % 2));
            chk("t2_result", out_result, (k % 2 == 1) ? 32'hF800_0000 : 32'd0);
            chk("t2_zero", 32'(out_zero), (k % 2 == 1) ? 32'd0 : 32'd1);
        end
        req_valid = '0;
        cycle();

        // Backpressure
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        set_req(0, 1, 32'd1, 32'd2, 4'd0);
        cycle();
        req_valid = '0;
        out_ready = 1'b0;
        set_req(1, 1, 32'd1, 32'hFFFF_FFFF, 4'd9);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t3_stall_rdy", 32'(req_ready), 32'd0);
            chk("t3_hold", out_result, 32'd3);
        end
        out_ready = 1'b1;
        #1;
        chk("t3_release_rdy", 32'(req_ready), 32'h2);
        cycle();
        chk("t3_result", out_result, 32'd1);
        chk("t3_id", 32'(out_id), 32'd1);
        req_valid = '0;

        // Signed vs unsigned compare, then a reserved opcode
        set_req(0, 1, 32'hFFFF_FFFF, 32'd1, 4'd8);
        cycle();
        chk("t4_slt", out_result, 32'd1);
        set_req(0, 1, 32'hFFFF_FFFF, 32'd1, 4'd9);
        cycle();
        chk("t4_sltu", out_result, 32'd0);
        set_req(0, 1, 32'd7, 32'd9, 4'd12);
        cycle();
        chk("t5_result", out_result, 32'd0);
        chk("t5_zero", 32'(out_zero), 32'd1);
        req_valid = '0;
        cycle();

        // Reset mid-stall
        set_req(0, 1, 32'd20, 32'd22, 4'd0);
        cycle();
        req_valid = '0;
        out_ready = 1'b0;
        cycle();
        chk("t6_stalled", 32'(out_valid), 32'd1);
        rst = 1'b1;
        set_req(0, 1, 32'd4, 32'd4, 4'd0);
        set_req(1, 1, 32'd6, 32'd6, 4'd0);
        cycle();
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_result", out_result, 32'd0);
        rst = 1'b0;
        cycle();
        chk("t6_id", 32'(out_id), 32'd0);
        chk("t6_sum", out_result, 32'd8);
        out_ready = 1'b1;
        req_valid = '0;
        cycle();

        // Randomized traffic; requesters hold their operation until it is accepted
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                logic [31:0] a, b;
                if (!(req_valid[i] && !(last_acc && last_win == i))) begin
                    a = rand_word();
                    b = ($urandom_range(0, 3) == 0) ? a : rand_word();
                    set_req(i, ($urandom_range(0, 2) != 0), a, b, 4'($urandom_range(0, 15)));
                end
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 32-bit single-cycle ALU datapath between NREQ independent requesters, e.g. the integer pipe, an address-generation unit and a debug port.
- Each requester presents operands and a 4-bit opcode with a valid/ready handshake.
- The block grants one requester per cycle by round-robin, evaluates the operation, and registers the result with the winner's ID on a single backpressured output channel.

Parameters:
- NREQ, 2, number of requesters (2..8).
- ID_W, $clog2(NREQ) (minimum 1), width of requester ID.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NREQ  per-requester operation valid
- req_ready  output  NREQ  per-requester accept; a transfer occurs when valid and ready are both high
- req_a  input  32*NREQ  operand A, requester i at bits [32i+31:32i]
- req_b  input  32*NREQ  operand B, same packing
- req_op  input  4*NREQ  opcode, requester i at [4i+3:4i]
- out_valid  output  1  registered result valid
- out_ready  input  1  consumer accepts result
- out_result  output  32  registered ALU result
- out_zero  output  1  registered (out_result == 0)
- out_id  output  ID_W  index of requester that issued the result

Behaviour:
- Reset values: out_valid=0, out_result=0, out_zero=0, out_id=0, rr_ptr=0.
- req_ready is 0 combinationally while rst is high.
- Opcode encoding, shift amount B[4:0]:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor
  - 5 sll, 6 srl, 7 sra
  - 8 slt signed, 9 sltu (result 1 or 0)
  - 10..15 give result 0, zero=1.
- Arithmetic wraps modulo 2^32; no overflow flag.
- can_issue = !out_valid || out_ready. The output stage is one register and may be refilled in the cycle it drains.
- Arbitration is combinational:
  - Scan indices rr_ptr, rr_ptr+1, ... mod NREQ.
  - The first i with req_valid[i]=1 is the winner.
  - req_ready[winner] = can_issue; every other req_ready bit = 0.
  - With no valid request, all req_ready bits are 0.
- req_ready never depends on a requester's own req_valid beyond arbitration. A requester must hold a, b and op stable while valid and not accepted.
- Accept cycle (any valid && can_issue):
  - out_valid<=1.
  - out_result<=op(a,b) of the winner.
  - out_zero<=(that result==0).
  - out_id<=winner.
  - rr_ptr<=(winner+1) mod NREQ.
- No accept and out_ready=1: out_valid<=0. out_result, out_zero and out_id hold their last values.
- No accept and out_valid=1 and out_ready=0: all output registers hold (stall).
- Latency: result appears on out_* the cycle after acceptance. Sustained throughput is 1 op/cycle when out_ready stays high.
- Fairness: a continuously valid requester is granted within NREQ accepts.
- rr_ptr advances only on accept; it does not change during a stall.
- Simultaneous drain and accept in one cycle: the new result replaces the old one and out_valid stays 1, with no bubble.
- Reset mid-operation: any pending result is discarded, out_valid goes 0 next cycle, and rr_ptr returns to 0. Requesters must re-present unaccepted operations.

Decomposition:
- Package alu_share_pkg holds:
  - the opcode localparams (OP_ADD..OP_SLTU)
  - a function alu_eval(a, b, op) returning the 32-bit result, shared with other ALU users.
- One sub-module, rr_pick: inputs valid vector and pointer; outputs one-hot grant, binary winner index and any_valid.
- Top level holds the operand mux, the alu_eval call and the output register.

Test Plan:
- Reset then single request:
  - Stimulus: rst for 2 cycles, then req0 a=5, b=3, op=0, out_ready=1.
  - Response: req_ready[0]=1 same cycle; next cycle out_valid=1, out_result=8, out_zero=0, out_id=0.
- Contention, NREQ=2:
  - Stimulus: both valid continuously; req0 sub 10-10, req1 sra 0x80000000>>4; out_ready=1.
  - Response: grants alternate 0,1,0,1. Results alternate out_result=0 with out_zero=1, and 0xF8000000.
- Backpressure:
  - Stimulus: out_ready=0 after the first result, req1 valid with sltu a=1, b=0xFFFFFFFF.
  - Response: req_ready all 0, out_* frozen for 5 cycles, rr_ptr unchanged. Raising out_ready accepts req1 the same cycle, and out_result=1 follows.
- Signed vs unsigned compare:
  - Stimulus: a=0xFFFFFFFF, b=1, op=8 then op=9.
  - Response: results 1 then 0.
- Undefined opcode 12 with a=7, b=9:
  - Response: out_result=0, out_zero=1.
- Reset mid-stall:
  - Stimulus: out_valid=1, out_ready=0, assert rst for one cycle.
  - Response: out_valid=0 and out_result=0 next cycle; with both requesters valid, the next grant goes to requester 0.
